// File: rtl/fifo_pkg.sv
// Shared defaults for the parametrised FIFO family and the depth helper used by RTL and bench.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF     = 32'd8;
  localparam int unsigned ADDR_W_DEF     = 32'd4;
  localparam int unsigned AFULL_LVL_DEF  = 32'd12;
  localparam int unsigned AEMPTY_LVL_DEF = 32'd4;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous-address read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, watermarks, flush and sticky error flags.
// Optional build macro FIFO_FWFT_EN selects first-word fall-through; default is registered read.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned AFULL_LVL  = AFULL_LVL_DEF,
  parameter int unsigned AEMPTY_LVL = AEMPTY_LVL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic              r_overflow;
  logic              r_underflow;
  logic [ADDR_W:0]   w_count;
  logic [31:0]       w_count_ext;
  logic              w_full;
  logic              w_empty;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [DATA_W-1:0] w_rd_data;

  assign w_count     = r_wptr - r_rptr;
  assign w_count_ext = {{(31 - ADDR_W){1'b0}}, w_count};
  assign w_full      = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                       (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_empty     = (r_wptr == r_rptr);

  // Flush wins over both requests, so nothing is written or popped in a flush cycle.
  assign w_rd_acc = rd & ~w_empty & ~flush;
  assign w_wr_acc = wr & (~w_full | w_rd_acc) & ~flush;

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[ADDR_W-1:0]),
    .i_wdata (data_in),
    .i_raddr (r_rptr[ADDR_W-1:0]),
    .o_rdata (w_rd_data)
  );

  // Read/write pointer advance on accepted requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd_acc) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr & ~w_wr_acc) r_overflow  <= 1'b1;
      if (rd & w_empty)   r_underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = w_rd_data;
`else
  logic [DATA_W-1:0] r_data_out;

  // Registered read data, held until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else if (flush) begin
      r_data_out <= '0;
    end else if (w_rd_acc) begin
      r_data_out <= w_rd_data;
    end
  end

  assign data_out = r_data_out;
`endif

  assign fifo_count        = w_count;
  assign fifo_full         = w_full;
  assign fifo_empty        = w_empty;
  assign fifo_almost_full  = (w_count_ext >= AFULL_LVL);
  assign fifo_almost_empty = (w_count_ext <= AEMPTY_LVL);
  assign fifo_overflow     = r_overflow;
  assign fifo_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int unsigned DW    = DATA_W_DEF;
  localparam int unsigned AW    = ADDR_W_DEF;
  localparam int unsigned DEPTH = fifo_depth(AW);

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          flush   = 1'b0;
  logic          wr      = 1'b0;
  logic          rd      = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic          fifo_overflow, fifo_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  logic [DW-1:0] m_dout = '0;

  fifo_sync_param dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .wr                (wr),
    .data_in           (data_in),
    .rd                (rd),
    .data_out          (data_out),
    .fifo_count        (fifo_count),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_overflow     (fifo_overflow),
    .fifo_underflow    (fifo_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    check({tag, ":count"},  32'(fifo_count),        32'(sz));
    check({tag, ":full"},   32'(fifo_full),         32'(sz == int'(DEPTH)));
    check({tag, ":empty"},  32'(fifo_empty),        32'(sz == 0));
    check({tag, ":afull"},  32'(fifo_almost_full),  32'(sz >= int'(AFULL_LVL_DEF)));
    check({tag, ":aempty"}, 32'(fifo_almost_empty), 32'(sz <= int'(AEMPTY_LVL_DEF)));
    check({tag, ":ovf"},    32'(fifo_overflow),     32'(m_ovf));
    check({tag, ":unf"},    32'(fifo_underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
    if (sz > 0) check({tag, ":dout"}, 32'(data_out), 32'(q[0]));
`else
    check({tag, ":dout"}, 32'(data_out), 32'(m_dout));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = '0;
  endtask

  // One clock of traffic: drive, clock, update the model from the pre-edge state, compare.
  task automatic step(input logic i_wr, input logic [DW-1:0] i_d, input logic i_rd,
                      input logic i_fl, input string tag);
    bit emp, ful, racc, wacc;
    wr = i_wr; data_in = i_d; rd = i_rd; flush = i_fl;
    @(posedge clk);
    emp  = (q.size() == 0);
    ful  = (q.size() == int'(DEPTH));
    racc = i_rd && !emp;
    wacc = i_wr && (!ful || racc);
    if (i_fl) begin
      model_reset();
    end else begin
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(i_d);
      if (i_wr && !wacc) m_ovf = 1'b1;
      if (i_rd && emp)   m_unf = 1'b1;
    end
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int writes;
    int cyc;
    bit rw, rr;
    logic [DW-1:0] rd_byte;

    #1 rst_n = 1'b0;
    #2 check_all("reset");
    #19 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "fill");
    check("fill16_full", 32'(fifo_full), 32'd1);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");
    check("drain_empty", 32'(fifo_empty), 32'd1);

    for (int i = 0; i < 16; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, "fill_ovf");
    step(1'b1, DW'(8'hAA), 1'b0, 1'b0, "ovf");
    check("ovf_count", 32'(fifo_count), 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, "drain_ovf");

    for (int i = 0; i < 16; i++) step(1'b1, DW'(8'h20 + i), 1'b0, 1'b0, "fill_rw");
    step(1'b1, DW'(8'h55), 1'b1, 1'b0, "full_rw");
    check("full_rw_head", 32'(data_out), 32'h20);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, "drain_rw");
    check("rw_last_55", 32'(data_out), 32'h55);

    step(1'b0, '0, 1'b1, 1'b0, "unf");
    check("unf_flag", 32'(fifo_underflow), 32'd1);
    step(1'b1, DW'(8'h3C), 1'b1, 1'b0, "empty_rw");
    check("empty_rw_count", 32'(fifo_count), 32'd1);

    for (int i = 0; i < 6; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, "pre_flush");
    step(1'b1, DW'(8'h77), 1'b0, 1'b1, "flush");
    check("flush_dout", 32'(data_out), 32'd0);

    writes = 0;
    cyc    = 0;
    while (writes < 40 && cyc < 400) begin
      rw = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < 50);
      rd_byte = DW'($urandom);
      if (rw && (q.size() < int'(DEPTH) || (rr && q.size() > 0))) writes++;
      step(rw, rd_byte, rr, 1'b0, "rand");
      cyc++;
    end
    check("rand_budget", 32'(writes), 32'd40);
    cyc = 0;
    while (q.size() > 0 && cyc < 40) begin
      step(1'b0, '0, 1'b1, 1'b0, "rand_drain");
      cyc++;
    end

    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h60 + i), 1'b1, 1'b0, "burst");
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, DW'(8'h99), 1'b0, 1'b0, "post_reset");
    step(1'b0, '0, 1'b1, 1'b0, "post_reset_rd");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO, the next generation of the team's 8-bit × 16 FIFO. It generalises data width and depth and adds an occupancy count, almost-full/almost-empty watermarks and a synchronous flush. It accepts a write on full when a read pops in the same cycle, and keeps sticky overflow/underflow error flags. It sits between any producer/consumer pair in the same clock domain and drops in for the fixed-size FIFO with ports of the same names.

## Interface
- DATA_W, 8: data word width in bits.
- ADDR_W, 4: address width; depth = 2**ADDR_W entries.
- AFULL_LVL, 12: almost-full watermark, in entries.
- AEMPTY_LVL, 4: almost-empty watermark, in entries.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- flush  in  1  synchronous clear of contents and error flags.
- wr  in  1  write request.
- data_in  in  DATA_W  write data.
- rd  in  1  read request.
- data_out  out  DATA_W  read data.
- fifo_count  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- fifo_full, fifo_empty  out  1  occupancy == depth / == 0.
- fifo_almost_full  out  1  fifo_count >= AFULL_LVL.
- fifo_almost_empty  out  1  fifo_count <= AEMPTY_LVL.
- fifo_overflow, fifo_underflow  out  1  sticky error flags.

## Operation
- Pointers
  - wptr and rptr are ADDR_W+1 bits; the MSB is the wrap bit. Both roll from 2**(ADDR_W+1)-1 to 0.
  - fifo_count = wptr - rptr, modulo 2**(ADDR_W+1).
  - full: MSBs differ and low ADDR_W bits are equal. empty: wptr == rptr.
- Read accept: rd_acc = rd & ~fifo_empty.
- Write accept: wr_acc = wr & (~fifo_full | rd_acc). A write on full is accepted when a read is accepted the same cycle; the count is unchanged.
- Both requests on empty: only the write is accepted, and underflow is set.
- Error flags
  - fifo_overflow is set when wr & ~wr_acc. fifo_underflow is set when rd & fifo_empty.
  - Both stay set until flush or reset.
  - A rejected request changes no pointer and no data.
- flush
  - Sets wptr = rptr = 0, clears both sticky flags and drives data_out to 0.
  - Overrides wr/rd in the same cycle; nothing is written, nothing is flagged.
- Reset values: pointers 0, data_out 0, fifo_count 0, fifo_empty 1, fifo_almost_empty 1, fifo_full 0, fifo_almost_full 0, fifo_overflow 0, fifo_underflow 0.
- Storage contents are not reset and are don't-care after reset or flush.
- Watermarks
  - Compared against fifo_count at full ADDR_W+1 width.
  - AFULL_LVL above depth means the flag never asserts. AEMPTY_LVL of 0 asserts the flag only on empty.

## Timing
- Pointers, error flags and data_out are registered on the rising clk edge.
- Status outputs are combinational from the registered pointers, so they are valid in the cycle after the accepting edge.
- Read latency (default build): data_out is loaded on the edge that accepts rd and holds until the next accepted read.
- Write-to-read: a word written at edge N is readable (fifo_empty=0) from edge N onward; rd asserted in cycle N+1 returns it at edge N+1.
- Error flags assert in the cycle following the offending request edge.
- rst_n assertion mid-transfer clears state immediately and asynchronously. Deassertion is synchronised externally; the first accepted operation is on the first rising edge after release.

## Configuration
- FIFO_FWFT_EN defined: first-word fall-through.
  - data_out shows the head entry combinationally from storage whenever fifo_empty=0; rd pops it.
  - data_out is don't-care while empty, and flush has no register to clear.
  - Flags and acceptance rules are unchanged.
- FIFO_FWFT_EN undefined: registered read with one-cycle latency, as described in Timing.

## Structure
- Shared package fifo_pkg holds the default values of DATA_W, ADDR_W, AFULL_LVL and AEMPTY_LVL. It also holds a depth function (2**ADDR_W) reused by the bench.
- One sub-module, fifo_ram: 2**ADDR_W × DATA_W storage with one synchronous write port and one read port (asynchronous read address), indexed by the low ADDR_W pointer bits.
- Pointer, flag and count logic lives in the top module.

## Test plan
- Reset, then 16 writes of 0x00..0x0F → count 16, full=1, almost_full asserted at count 12, then 16 reads return 0x00..0x0F in order; empty=1, almost_empty asserted at count 4.
- Fill to 16, assert wr=1 with data 0xAA alone → overflow=1 on the next cycle, count stays 16, subsequent reads never return 0xAA.
- Full, then wr=1 and rd=1 with data 0x55 → read returns the head word, count stays 16, 0x55 emerges as the 16th read.
- Empty, then rd=1 → underflow=1, data_out unchanged; wr=1 and rd=1 on empty → count becomes 1, underflow=1.
- 40 writes interleaved with reads (wrap twice) → data order preserved, count matches the scoreboard every cycle.
- flush with 7 entries and wr=1 in the same cycle → count 0, empty=1, both error flags 0, data_out 0. rst_n pulsed mid-burst → all outputs at reset values immediately.
